// File: rtl/frame_pixel_reader_if.sv
// Pixel-side bundle of the frame reader: synchronous memory read port plus
// the pixel/x/y write-ready handshake toward the display or feature path.
interface frame_pixel_reader_if #(
    parameter int ADDR_W  = 17,
    parameter int PIXEL_W = 16
);
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIXEL_W-1:0] mem_data;
    logic [7:0]         x_addr;
    logic [8:0]         y_addr;
    logic [PIXEL_W-1:0] pixel;
    logic               pixel_write;
    logic               pixel_ready;

    modport master (
        output mem_rd_en, mem_addr, x_addr, y_addr, pixel, pixel_write,
        input  mem_data, pixel_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, x_addr, y_addr, pixel, pixel_write,
        output mem_data, pixel_ready
    );
endinterface

// File: rtl/frame_pixel_reader.sv
// Replays one stored WIDTH x HEIGHT frame from a 1-cycle-latency pixel memory
// in raster order, presenting each pixel with its coordinates on write/ready.
module frame_pixel_reader #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int PIXEL_W = 16,
    parameter int ADDR_W  = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_frame_done,
    frame_pixel_reader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [7:0]        X_LAST   = 8'(WIDTH - 1);
    localparam logic [8:0]        Y_LAST   = 9'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t               r_state,       w_state_nxt;
    logic [7:0]           r_x_cnt,       w_x_cnt_nxt;
    logic [8:0]           r_y_cnt,       w_y_cnt_nxt;
    logic [ADDR_W-1:0]    r_addr,        w_addr_nxt;
    logic                 r_mem_rd_en,   w_mem_rd_en_nxt;
    logic [PIXEL_W-1:0]   r_pixel,       w_pixel_nxt;
    logic [7:0]           r_x_addr,      w_x_addr_nxt;
    logic [8:0]           r_y_addr,      w_y_addr_nxt;
    logic                 r_pixel_write, w_pixel_write_nxt;
    logic                 r_busy,        w_busy_nxt;
    logic                 r_frame_done,  w_frame_done_nxt;

    logic                 w_xfer;
    logic                 w_last;

    assign w_xfer = (r_state == S_PRESENT) && bus.pixel_ready;
    assign w_last = (r_x_cnt == X_LAST) && (r_y_cnt == Y_LAST);

    // The linear address runs alongside x/y so it always equals y*WIDTH+x
    // without a multiplier.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        w_state_nxt       = r_state;
        w_x_cnt_nxt       = r_x_cnt;
        w_y_cnt_nxt       = r_y_cnt;
        w_addr_nxt        = r_addr;
        w_mem_rd_en_nxt   = 1'b0;
        w_pixel_nxt       = r_pixel;
        w_x_addr_nxt      = r_x_addr;
        w_y_addr_nxt      = r_y_addr;
        w_pixel_write_nxt = r_pixel_write;
        w_busy_nxt        = r_busy;
        w_frame_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_x_cnt_nxt = '0;
                w_y_cnt_nxt = '0;
                w_addr_nxt  = '0;
                if (i_start) begin
                    w_state_nxt     = S_READ;
                    w_mem_rd_en_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_READ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_pixel_nxt       = bus.mem_data;
                w_x_addr_nxt      = r_x_cnt;
                w_y_addr_nxt      = r_y_cnt;
                w_pixel_write_nxt = 1'b1;
                w_state_nxt       = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_xfer) begin
                    w_pixel_write_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt      = S_DONE;
                        w_frame_done_nxt = 1'b1;
                        w_busy_nxt       = 1'b0;
                    end else begin
                        if (r_x_cnt == X_LAST) begin
                            w_x_cnt_nxt = '0;
                            w_y_cnt_nxt = r_y_cnt + 9'd1;
                        end else begin
                            w_x_cnt_nxt = r_x_cnt + 8'd1;
                        end
                        w_addr_nxt      = r_addr + ADDR_ONE;
                        w_mem_rd_en_nxt = 1'b1;
                        w_state_nxt     = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state       <= S_IDLE;
            r_x_cnt       <= '0;
            r_y_cnt       <= '0;
            r_addr        <= '0;
            r_mem_rd_en   <= 1'b0;
            r_pixel       <= '0;
            r_x_addr      <= '0;
            r_y_addr      <= '0;
            r_pixel_write <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_x_cnt       <= w_x_cnt_nxt;
            r_y_cnt       <= w_y_cnt_nxt;
            r_addr        <= w_addr_nxt;
            r_mem_rd_en   <= w_mem_rd_en_nxt;
            r_pixel       <= w_pixel_nxt;
            r_x_addr      <= w_x_addr_nxt;
            r_y_addr      <= w_y_addr_nxt;
            r_pixel_write <= w_pixel_write_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_done  <= w_frame_done_nxt;
        end
    end

    assign bus.mem_rd_en   = r_mem_rd_en;
    assign bus.mem_addr    = r_addr;
    assign bus.pixel       = r_pixel;
    assign bus.x_addr      = r_x_addr;
    assign bus.y_addr      = r_y_addr;
    assign bus.pixel_write = r_pixel_write;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_frame_done;

endmodule

// File: tb/tb_frame_pixel_reader.sv
// Scoreboard bench for frame_pixel_reader: full 240-pixel lines on a short
// frame, memory returns data = address, monitor checks every read and transfer.
module tb_frame_pixel_reader;

    localparam int W    = 240;
    localparam int H    = 6;
    localparam int PW   = 16;
    localparam int AW   = 17;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] pix;
    } px_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    frame_pixel_reader_if #(.ADDR_W(AW), .PIXEL_W(PW)) bus ();

    frame_pixel_reader #(
        .WIDTH  (W),
        .HEIGHT (H),
        .PIXEL_W(PW),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Memory model: data = address one cycle after the strobe, junk otherwise.
    always @(posedge clk) bus.mem_data <= bus.mem_rd_en ? 16'(bus.mem_addr) : 16'hDEAD;

    px_t           exp_q[$];
    logic [AW-1:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int dones  = 0;
    int bad_x  = 0;
    logic [7:0]    last_x    = '0;
    logic [8:0]    last_y    = '0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event did not occur in time", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reads memory or transfers.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_en) begin
                if (addr_q.size() == 0) fail_now("unexpected_mem_rd");
                else check("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
                last_addr = bus.mem_addr;
            end
            if (bus.pixel_write && bus.x_addr >= 8'(W)) bad_x++;
            if (bus.pixel_write && bus.pixel_ready) begin
                xfers++;
                last_x = bus.x_addr;
                last_y = bus.y_addr;
                if (exp_q.size() == 0) fail_now("unexpected_xfer");
                else check("xfer_xy_pix", 64'({bus.x_addr, bus.y_addr, bus.pixel}),
                           64'(exp_q.pop_front()));
            end
            if (frame_done) dones++;
        end
    end

    task automatic push_frame();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back('{x: 8'(x), y: 9'(y), pix: 16'(y * W + x)});
                addr_q.push_back(AW'(y * W + x));
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({busy, frame_done, bus.mem_rd_en, bus.mem_addr, bus.x_addr,
                         bus.y_addr, bus.pixel, bus.pixel_write}), 64'd0);
    endtask

    // Starts a frame from IDLE; c0 is the cycle number of the start cycle.
    task automatic start_frame(output int c0);
        push_frame();
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        check("idle_before_start", 64'({frame_done, busy}), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // From start cycle N: read at N+1, present pixel (0,0) at N+3.
    task automatic check_first();
        @(negedge clk);
        check("n1_rd_addr_busy", 64'({bus.mem_rd_en, bus.mem_addr, busy, bus.pixel_write}),
              64'({1'b1, AW'(0), 1'b1, 1'b0}));
        @(negedge clk);
        check("n2_wait", 64'({bus.mem_rd_en, bus.pixel_write}), 64'd0);
        @(negedge clk);
        check("n3_first_pixel", 64'({bus.pixel_write, bus.x_addr, bus.y_addr, bus.pixel}),
              64'({1'b1, 8'd0, 9'd0, 16'h0000}));
    endtask

    task automatic wait_pix(input int x, input int y);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.pixel_write && bus.x_addr == 8'(x) && bus.y_addr == 9'(y)) && n < 5000);
        if (!(bus.pixel_write && bus.x_addr == 8'(x) && bus.y_addr == 9'(y))) fail_now("wait_pixel");
    endtask

    task automatic wait_done(output int cd);
        int n = 0;
        while (!frame_done && n < 3 * NPIX + 100) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) fail_now("wait_frame_done");
        cd = cyc;
    endtask

    task automatic check_frame_end(input string name, input int c0, input int cd,
                                   input int x0, input int stalls);
        // Inclusive count from the start cycle through the frame_done cycle.
        check({name, "_length"}, 64'(cd - c0 + 1), 64'(3 * NPIX + 2 + stalls));
        check({name, "_last_xy"}, 64'({last_x, last_y}), 64'({8'(W - 1), 9'(H - 1)}));
        check({name, "_last_addr"}, 64'(last_addr), 64'(NPIX - 1));
        check({name, "_xfers"}, 64'(xfers - x0), 64'(NPIX));
        check({name, "_busy_low"}, 64'(busy), 64'd0);
        check({name, "_queues_empty"}, 64'(exp_q.size() + addr_q.size()), 64'd0);
    endtask

    initial begin
        int c0, cd, x0, d0;
        bus.pixel_ready = 1'b1;

        // Reset held with start asserted: everything stays 0.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_ignored_in_reset", 64'({busy, bus.mem_rd_en}), 64'd0);

        // Frame 1: first-pixel latency, second pixel, backpressure on (5,2).
        x0 = xfers;
        start_frame(c0);
        check_first();
        @(negedge clk);
        check("n4_write_drop", 64'(bus.pixel_write), 64'd0);
        repeat (2) @(negedge clk);
        check("n6_second_pixel", 64'({bus.pixel_write, bus.x_addr, bus.y_addr, bus.pixel}),
              64'({1'b1, 8'd1, 9'd0, 16'h0001}));

        wait_pix(4, 2);
        @(posedge clk);
        #1 bus.pixel_ready = 1'b0;
        wait_pix(5, 2);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", 64'({bus.pixel_write, bus.mem_rd_en, bus.x_addr, bus.y_addr, bus.pixel}),
                  64'({1'b1, 1'b0, 8'd5, 9'd2, 16'd485}));
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.pixel_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 64'({bus.pixel_write, bus.x_addr, bus.y_addr}),
              64'({1'b1, 8'd5, 9'd2}));
        @(negedge clk);
        check("resume_read", 64'({bus.mem_rd_en, bus.mem_addr, bus.pixel_write}),
              64'({1'b1, AW'(486), 1'b0}));
        repeat (2) @(negedge clk);
        check("resume_cadence", 64'({bus.pixel_write, bus.x_addr, bus.y_addr, bus.pixel}),
              64'({1'b1, 8'd6, 9'd2, 16'd486}));
        wait_done(cd);
        check_frame_end("frame1", c0, cd, x0, 5);

        // Frame 2: restarted the cycle after frame_done, ready high throughout.
        x0 = xfers;
        start_frame(c0);
        check_first();
        wait_pix(W - 1, 0);
        @(negedge clk);
        check("wrap_read_addr", 64'({bus.mem_rd_en, bus.mem_addr}), 64'({1'b1, AW'(W)}));
        repeat (2) @(negedge clk);
        check("wrap_pixel", 64'({bus.pixel_write, bus.x_addr, bus.y_addr, bus.pixel}),
              64'({1'b1, 8'd0, 9'd1, 16'h00F0}));
        wait_done(cd);
        check_frame_end("frame2", c0, cd, x0, 0);
        @(negedge clk);
        check("done_one_cycle", 64'({frame_done, busy}), 64'd0);

        // Frame 3: start while busy is ignored, then reset mid-frame.
        d0 = dones;
        start_frame(c0);
        wait_pix(100, 0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_extra_start", 64'(busy), 64'd1);
        wait_pix(200, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        start = 1'b1;
        #1 check_all_zero("async_reset_outputs");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        check_all_zero("reset_held_outputs");
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", 64'({dones, busy, bus.mem_rd_en}), 64'({d0, 1'b0, 1'b0}));

        // Frame 4: fresh frame from (0,0) after the abort.
        x0 = xfers;
        start_frame(c0);
        check_first();
        wait_done(cd);
        check_frame_end("frame4", c0, cd, x0, 0);

        check("no_x_overflow", 64'(bad_x), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
